regfile_wr_arb: RTL and testbench

Round-robin arbiter sharing the two write ports of the 32×32 register file among `NREQ` requesters (ALU writeback, load unit, branch/link unit, interrupt stacker). Accepts requests over a valid/ready handshake and grants up to two per cycle. It drives the register file's `wa0/wd0/wa1/wd1/write` from registered outputs. It also keeps writes off r28 (status) and r31 (PC) in cycles where the core's own status-write or PC-increment would collide.

---
 rtl/regfile_wr_arb.sv | 97 +++++++++
 tb/tb_regfile_wr_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: round-robin arbiter granting up to two register-file writes per cycle,
// guarding r28/r31 against collisions with the core's own status/PC writes.
module regfile_wr_arb #(
  parameter int NREQ = 4,
  parameter int addrsize = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*addrsize-1:0]   req_addr,
  input  logic [NREQ*32-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       st_next,
  input  logic                       pc_next,
  output logic [addrsize-1:0]        wa0,
  output logic [addrsize-1:0]        wa1,
  output logic [31:0]                wd0,
  output logic [31:0]                wd1,
  output logic [1:0]                 write,
  output logic [$clog2(NREQ)-1:0]    rr_ptr
);
  localparam int PW = $clog2(NREQ);
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     grant;
  logic                found_a;
  logic                found_b;
  logic [PW-1:0]       idx_a;
  logic [PW-1:0]       idx_b;
  logic [PW-1:0]       last;
  logic [PW-1:0]       ptr_next;
  logic [addrsize-1:0] addr_a;
  logic [addrsize-1:0] addr_b;
  logic [31:0]         data_a;
  logic [31:0]         data_b;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i]
        && !(st_next && req_addr[i*addrsize +: addrsize] == addrsize'(28))
        && !(pc_next && req_addr[i*addrsize +: addrsize] == addrsize'(31));
  end
  // B skips any eligible requester aiming at A's register, so one register never takes two writes.
  always_comb begin
    int j;
    j = 0;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (elig[j]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a = PW'(j);
        end else if (!found_b && req_addr[j*addrsize +: addrsize] != req_addr[int'(idx_a)*addrsize +: addrsize]) begin
          found_b = 1'b1;
          idx_b = PW'(j);
        end
      end
    end
  end
  always_comb begin
    grant = '0;
    if (found_a) grant[idx_a] = 1'b1;
    if (found_b) grant[idx_b] = 1'b1;
  end
  assign req_ready = rst ? grant : '0;
  assign addr_a = req_addr[int'(idx_a)*addrsize +: addrsize];
  assign addr_b = req_addr[int'(idx_b)*addrsize +: addrsize];
  assign data_a = req_data[int'(idx_a)*32 +: 32];
  assign data_b = req_data[int'(idx_b)*32 +: 32];
  assign last = found_b ? idx_b : idx_a;
  assign ptr_next = (last == PW'(NREQ-1)) ? '0 : last + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write  <= '0;
      wa0    <= '0;
      wa1    <= '0;
      wd0    <= '0;
      wd1    <= '0;
      rr_ptr <= '0;
    end else begin
      write <= {found_b, found_a};
      if (found_a) begin
        wa0    <= addr_a;
        wd0    <= data_a;
        rr_ptr <= ptr_next;
      end
      if (found_b) begin
        wa1 <= addr_b;
        wd1 <= data_b;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_regfile_wr_arb;
  localparam int N = 4;
  localparam int AW = 5;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            st_next;
  logic            pc_next;
  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [31:0]     wd0;
  logic [31:0]     wd1;
  logic [1:0]      write;
  logic [1:0]      rr_ptr;
  int checks = 0;
  int passes = 0;
  int m_ptr;
  logic [1:0]  m_write;
  logic [4:0]  m_wa0;
  logic [4:0]  m_wa1;
  logic [31:0] m_wd0;
  logic [31:0] m_wd1;
  int ga;
  int gb;
  logic [3:0] obs_ready;
  always #5 clk = ~clk;
  regfile_wr_arb #(.NREQ(N), .addrsize(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .st_next(st_next), .pc_next(pc_next), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .write(write), .rr_ptr(rr_ptr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [4:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction
  function automatic logic [31:0] data_of(input int i);
    return req_data[i*32 +: 32];
  endfunction
  function automatic logic blocked(input logic [4:0] a);
    return (st_next && a == 5'd28) || (pc_next && a == 5'd31);
  endfunction
  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*32 +: 32] = d;
  endtask
  task automatic model_reset();
    m_ptr = 0;
    m_write = '0;
    m_wa0 = '0;
    m_wa1 = '0;
    m_wd0 = '0;
    m_wd1 = '0;
    ga = -1;
    gb = -1;
  endtask
  task automatic model_grant();
    int q[$];
    q = {};
    ga = -1;
    gb = -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N] && !blocked(addr_of((m_ptr + k) % N))) q.push_back((m_ptr + k) % N);
    if (q.size() > 0) begin
      ga = q[0];
      for (int k = 1; k < q.size(); k++)
        if (addr_of(q[k]) != addr_of(ga)) begin
          gb = q[k];
          break;
        end
    end
  endtask
  task automatic step();
    logic [3:0] mask;
    #2;
    model_grant();
    mask = '0;
    if (ga >= 0) mask[ga] = 1'b1;
    if (gb >= 0) mask[gb] = 1'b1;
    obs_ready = req_ready;
    check("ready", 32'(req_ready), 32'(mask));
    check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    @(posedge clk);
    #1;
    m_write = {gb >= 0, ga >= 0};
    if (ga >= 0) begin
      m_wa0 = addr_of(ga);
      m_wd0 = data_of(ga);
    end
    if (gb >= 0) begin
      m_wa1 = addr_of(gb);
      m_wd1 = data_of(gb);
    end
    m_ptr = (gb >= 0) ? (gb + 1) % N : (ga >= 0) ? (ga + 1) % N : m_ptr;
    check("write", 32'(write), 32'(m_write));
    check("wa0", 32'(wa0), 32'(m_wa0));
    check("wd0", wd0, m_wd0);
    check("wa1", 32'(wa1), 32'(m_wa1));
    check("wd1", wd1, m_wd1);
    check("rr_ptr_q", 32'(rr_ptr), 32'(m_ptr));
  endtask
  initial begin
    logic [4:0] tbl [6];
    tbl = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd28, 5'd31};
    st_next = 1'b0;
    pc_next = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'(100 + i));
    model_reset();
    #13;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_write", 32'(write), 32'h0);
    check("rst_wa0", 32'(wa0), 32'h0);
    check("rst_wa1", 32'(wa1), 32'h0);
    check("rst_wd0", wd0, 32'h0);
    check("rst_wd1", wd1, 32'h0);
    check("rst_ptr", 32'(rr_ptr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("rst_first_grant", 32'(obs_ready), 32'h3);
    step();
    check("rr_second", 32'(obs_ready), 32'hc);
    step();
    check("rr_third", 32'(obs_ready), 32'h3);
    check("rr_write", 32'(write), 32'h3);
    set_req(0, 1'b1, 5'd5, 32'hA);
    set_req(1, 1'b1, 5'd5, 32'hB);
    set_req(2, 1'b1, 5'd7, 32'hC);
    set_req(3, 1'b0, 5'd0, 32'h0);
    step();
    check("same_addr_grant", 32'(obs_ready), 32'h5);
    set_req(0, 1'b0, 5'd5, 32'hA);
    set_req(2, 1'b0, 5'd7, 32'hC);
    step();
    check("same_addr_second", 32'(obs_ready), 32'h2);
    check("same_addr_wd0", wd0, 32'hB);
    pc_next = 1'b1;
    set_req(0, 1'b1, 5'd31, 32'hD0);
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1'b1, 5'd3, 32'(32'h30 + c));
      step();
      check("pc_block", 32'(obs_ready), 32'h2);
    end
    pc_next = 1'b0;
    set_req(1, 1'b0, 5'd3, 32'h0);
    step();
    check("pc_release", 32'(obs_ready), 32'h1);
    check("pc_wa0", 32'(wa0), 32'd31);
    set_req(0, 1'b0, 5'd31, 32'h0);
    st_next = 1'b1;
    set_req(2, 1'b1, 5'd28, 32'h28A);
    set_req(3, 1'b1, 5'd28, 32'h28B);
    repeat (2) begin
      step();
      check("st_block", 32'(obs_ready), 32'h0);
    end
    st_next = 1'b0;
    step();
    check("st_first", 32'(obs_ready), 32'h4);
    set_req(2, 1'b0, 5'd28, 32'h0);
    step();
    check("st_second", 32'(obs_ready), 32'h8);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(10 + i), 32'(200 + i));
    step();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_write", 32'(write), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_ptr", 32'(rr_ptr), 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", 32'(write), 32'h0);
    rst = 1'b1;
    step();
    check("mid_rst_restart", 32'(obs_ready), 32'h3);
    for (int c = 0; c < 400; c++) begin
      st_next = ($urandom_range(0, 3) == 0);
      pc_next = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && i != ga && i != gb))
          set_req(i, $urandom_range(0, 3) != 0, tbl[$urandom_range(0, 5)], $urandom);
      step();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
